// File: rtl/history_pkg.sv
// Shared types and defaults for the history-FSM event window counter.
package history_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    localparam int HIST_WINDOW = 16;
    localparam int HIST_CNT_W  = $clog2(HIST_WINDOW + 1);

    typedef struct packed {
        logic [HIST_CNT_W-1:0] x_count;
        logic [HIST_CNT_W-1:0] y_count;
    } hist_result_t;

endpackage

// File: rtl/history_win_outbuf.sv
// Valid/ready result buffer: 1-entry register, or 2-entry in-order FIFO when
// HISTORY_WIN_SKID_EN is defined. Flags a push that finds the buffer full.
module history_win_outbuf #(
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          drop_o
);

`ifdef HISTORY_WIN_SKID_EN
    logic [DW-1:0] head_q, head_d, tail_q, tail_d;
    logic          vld0_q, vld0_d, vld1_q, vld1_d;
    logic          pop;

    assign pop     = vld0_q & ready_i;
    assign valid_o = vld0_q;
    assign data_o  = head_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        vld0_d = vld0_q;
        vld1_d = vld1_q;
        drop_o = 1'b0;
        if (pop && push_i) begin
            // head leaves; newcomer goes behind whatever remains
            if (vld1_q) begin
                head_d = tail_q;
                tail_d = push_data_i;
            end else begin
                head_d = push_data_i;
            end
        end else if (pop) begin
            head_d = tail_q;
            vld0_d = vld1_q;
            vld1_d = 1'b0;
        end else if (push_i) begin
            if (!vld0_q) begin
                head_d = push_data_i;
                vld0_d = 1'b1;
            end else if (!vld1_q) begin
                tail_d = push_data_i;
                vld1_d = 1'b1;
            end else begin
                drop_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            vld0_q <= 1'b0;
            vld1_q <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            vld0_q <= vld0_d;
            vld1_q <= vld1_d;
        end
    end
`else
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          pop;

    assign pop     = valid_q & ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        drop_o  = 1'b0;
        if (push_i) begin
            if (!valid_q || pop) begin
                data_d  = push_data_i;
                valid_d = 1'b1;
            end else begin
                drop_o = 1'b1;
            end
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
`endif

endmodule

// File: rtl/history_event_window.sv
// Counts history-FSM x/y assertions over back-to-back windows of WINDOW samples.
// Output buffer depth is 2 with HISTORY_WIN_SKID_EN defined, else 1.
module history_event_window
    import history_pkg::*;
#(
    parameter int WINDOW = HIST_WINDOW
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic                           sample_en,
    input  logic                           x_in,
    input  logic                           y_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(WINDOW+1)-1:0]    x_count,
    output logic [$clog2(WINDOW+1)-1:0]    y_count,
    output logic                           overrun
);

    localparam int CNT_W = $clog2(WINDOW + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] smp_q, smp_d;
    logic [CNT_W-1:0] x_acc_q, x_acc_d;
    logic [CNT_W-1:0] y_acc_q, y_acc_d;
    logic [CNT_W-1:0] x_nxt, y_nxt;
    logic             overrun_q;
    logic             push;
    logic             buf_drop;
    logic [2*CNT_W-1:0] buf_data;

    assign x_nxt = x_acc_q + CNT_W'(x_in);
    assign y_nxt = y_acc_q + CNT_W'(y_in);

    always_comb begin
        state_d = state_q;
        smp_d   = smp_q;
        x_acc_d = x_acc_q;
        y_acc_d = y_acc_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) state_d = ACCUM;
            end
            ACCUM: begin
                if (!enable) begin
                    // partial window is abandoned, never reported
                    state_d = IDLE;
                    smp_d   = '0;
                    x_acc_d = '0;
                    y_acc_d = '0;
                end else if (sample_en) begin
                    if (smp_q == CNT_W'(WINDOW - 1)) begin
                        push    = 1'b1;
                        smp_d   = '0;
                        x_acc_d = '0;
                        y_acc_d = '0;
                    end else begin
                        smp_d   = smp_q + 1'b1;
                        x_acc_d = x_nxt;
                        y_acc_d = y_nxt;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            smp_q     <= '0;
            x_acc_q   <= '0;
            y_acc_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_q     <= smp_d;
            x_acc_q   <= x_acc_d;
            y_acc_q   <= y_acc_d;
            overrun_q <= overrun_q | buf_drop;
        end
    end

    // completing sample is folded in on the way to the buffer
    history_win_outbuf #(
        .DW (2 * CNT_W)
    ) u_outbuf (
        .clk         (clk),
        .rst_n       (reset_n),
        .push_i      (push),
        .push_data_i ({x_nxt, y_nxt}),
        .ready_i     (out_ready),
        .valid_o     (out_valid),
        .data_o      (buf_data),
        .drop_o      (buf_drop)
    );

    assign x_count = buf_data[2*CNT_W-1:CNT_W];
    assign y_count = buf_data[CNT_W-1:0];
    assign overrun = overrun_q;

endmodule

// File: tb/tb_history_event_window.sv
// Randomized and directed checks of history_event_window against a queue-based model.
module tb_history_event_window;

    localparam int WINDOW = 16;
    localparam int CNT_W  = $clog2(WINDOW + 1);
`ifdef HISTORY_WIN_SKID_EN
    localparam int DEPTH  = 2;
`else
    localparam int DEPTH  = 1;
`endif

    logic             clk = 1'b0;
    logic             reset_n, enable, sample_en, x_in, y_in, out_ready;
    logic             out_valid, overrun;
    logic [CNT_W-1:0] x_count, y_count;

    history_event_window #(.WINDOW(WINDOW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .sample_en (sample_en),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_count   (x_count),
        .y_count   (y_count),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: window progress plus a queue of undelivered results
    bit m_act;
    int m_n, m_x, m_y;
    bit m_ovr;
    int qx[$], qy[$];
    int seen_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_n = 0; m_x = 0; m_y = 0; m_ovr = 0;
        qx.delete(); qy.delete();
    endtask

    task automatic step(input bit en, input bit se, input bit x, input bit y, input bit rdy);
        bit push;
        bit pop;
        int px, py;
        enable = en; sample_en = se; x_in = x; y_in = y; out_ready = rdy;
        @(posedge clk);
        push = 0; px = 0; py = 0;
        pop  = (qx.size() > 0) && rdy;
        if (!m_act) begin
            if (en) m_act = 1;
        end else if (!en) begin
            m_act = 0; m_n = 0; m_x = 0; m_y = 0;
        end else if (se) begin
            m_n++; m_x += int'(x); m_y += int'(y);
            if (m_n == WINDOW) begin
                push = 1; px = m_x; py = m_y;
                m_n = 0; m_x = 0; m_y = 0;
            end
        end
        if (pop) begin
            void'(qx.pop_front());
            void'(qy.pop_front());
        end
        if (push) begin
            if (qx.size() < DEPTH) begin
                qx.push_back(px);
                qy.push_back(py);
            end else begin
                m_ovr = 1;
            end
        end
        #1;
        chk("valid", 32'(out_valid), 32'(qx.size() > 0));
        if (qx.size() > 0) begin
            chk("x_count", 32'(x_count), 32'(qx[0]));
            chk("y_count", 32'(y_count), 32'(qy[0]));
        end
        chk("overrun", 32'(overrun), 32'(m_ovr));
        if (out_valid) seen_valid++;
    endtask

    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk({tag, "_valid"},   32'(out_valid), 0);
        chk({tag, "_x"},       32'(x_count),   0);
        chk({tag, "_y"},       32'(y_count),   0);
        chk({tag, "_overrun"}, 32'(overrun),   0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; enable = 0; sample_en = 0; x_in = 0; y_in = 0; out_ready = 0;
        model_reset();
        seen_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   32'(out_valid), 0);
        chk("rst_x",       32'(x_count),   0);
        chk("rst_y",       32'(y_count),   0);
        chk("rst_overrun", 32'(overrun),   0);
        @(negedge clk);
        reset_n = 1'b1;

        // IDLE cycle: this sample must not count
        step(1, 1, 1, 1, 1);

        // one window: x on 6 samples, y on 3
        for (int i = 0; i < WINDOW; i++) step(1, 1, i < 6, i < 3, 1);
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_x",     32'(x_count),   6);
        chk("t2_y",     32'(y_count),   3);
        step(1, 0, 1, 1, 1);

        // qualifier toggling: 32 qualified samples -> 2 results
        seen_valid = 0;
        for (int i = 0; i < 4 * WINDOW; i++) step(1, i[0], 1, $urandom_range(0, 1), 1);
        step(1, 0, 0, 0, 1);
        chk("t3_results", 32'(seen_valid), 2);

        // abort partial window
        for (int i = 0; i < 10; i++) step(1, 1, 1, 1, 1);
        step(0, 1, 1, 1, 1);
        step(1, 1, 1, 1, 1);
        for (int i = 0; i < WINDOW; i++) step(1, 1, i < 4, i < 1, 1);
        chk("t4_x", 32'(x_count), 4);
        chk("t4_y", 32'(y_count), 1);
        step(1, 0, 0, 0, 1);

        // backpressure across windows
        for (int i = 0; i < 2 * WINDOW; i++) step(1, 1, i[1], i[2], 0);
`ifdef HISTORY_WIN_SKID_EN
        chk("t5_ovr2", 32'(overrun), 0);
`else
        chk("t5_ovr2", 32'(overrun), 1);
`endif
        for (int i = 0; i < WINDOW; i++) step(1, 1, 1, 0, 0);
        chk("t5_ovr3", 32'(overrun), 1);

        // reset mid-window with results pending
        for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 0);
        async_reset("t1");
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < WINDOW; i++) step(1, 1, i < 7, i < 2, 1);
        chk("t1_x", 32'(x_count), 7);
        step(1, 0, 0, 0, 1);

        // completion coincides with pop of a pending result
        for (int i = 0; i < WINDOW; i++) step(1, 1, i < 2, 0, 0);
        for (int i = 0; i < WINDOW - 1; i++) step(1, 1, i < 5, i < 1, 0);
        step(1, 1, 0, 0, 1);
        chk("t6_valid",   32'(out_valid), 1);
        chk("t6_x",       32'(x_count),   5);
        chk("t6_y",       32'(y_count),   1);
        chk("t6_overrun", 32'(overrun),   0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 97,
                 $urandom_range(0, 99) < 70,
                 $urandom_range(0, 1),
                 $urandom_range(0, 1),
                 $urandom_range(0, 99) < 55);
            if (i == 1500) async_reset("rnd_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
